// File: rtl/dpram_access_ctrl.sv
// Memory-side access controller: owns a 2**ADDR_W x DATA_W RAM and turns sequencer
// RD/WR strobes into wait-state-paced accesses. Define DPRAM_PARITY_EN for stored even parity.
module dpram_access_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              ar,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DIn,
    input  logic              RD,
    input  logic              WR,
    output logic [DATA_W-1:0] DOut,
    output logic              Done,
    output logic              Busy,
    output logic              ParityErr
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 3;
`ifdef DPRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    if (WAIT_STATES > 4) begin : g_bad_wait_states
        $error("dpram_access_ctrl: WAIT_STATES must be in 0..4");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_e;

    state_e              state_q, state_d;
    logic                rd_q, rd_d, wr_q, wr_d;
    logic                wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   last_a_q, last_a_d, a_lat_q, a_lat_d;
    logic [DATA_W-1:0]   d_lat_q, d_lat_d, dout_q, dout_d;
    logic                op_wr_q, op_wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d, busy_q, busy_d;
    logic                perr_q, perr_d;
    logic                wr_start, rd_start, accept_wr, accept_rd, mem_we;
    logic [MEM_W-1:0]    mem_word, mem_wdata;

    logic [MEM_W-1:0] mem [DEPTH];

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (ar) begin
            state_q   <= ST_IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            last_a_q  <= '0;
            a_lat_q   <= '0;
            d_lat_q   <= '0;
            op_wr_q   <= 1'b0;
            cnt_q     <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            last_a_q  <= last_a_d;
            a_lat_q   <= a_lat_d;
            d_lat_q   <= d_lat_d;
            op_wr_q   <= op_wr_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
        end
    end

    // RAM array: no reset, written only in a WRITE access
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[a_lat_q] <= mem_wdata;
        end
    end

    // Next-state logic; a level strobe restarts only on a rise or an address change
    always_comb begin
        state_d   = state_q;
        wr_start  = (WR & ~wr_q) | (WR & wr_q & (A != last_a_q));
        rd_start  = (RD & ~rd_q) | (RD & rd_q & (A != last_a_q));
        accept_wr = (state_q == ST_IDLE) & (wr_start | wr_pend_q);
        accept_rd = (state_q == ST_IDLE) & ~accept_wr & (rd_start | rd_pend_q);
        case (state_q)
            ST_IDLE:   if (accept_wr | accept_rd) state_d = ST_WAIT;
            ST_WAIT:   if (cnt_q == '0) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rd_d      = RD;
        wr_d      = WR;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        last_a_d  = last_a_q;
        a_lat_d   = a_lat_q;
        d_lat_d   = d_lat_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        done_d    = done_q;
        perr_d    = perr_q;
        mem_word  = mem[a_lat_q];
        mem_we    = (state_q == ST_ACCESS) & op_wr_q & ~ar;
`ifdef DPRAM_PARITY_EN
        mem_wdata = {^d_lat_q, d_lat_q};
`else
        mem_wdata = d_lat_q;
`endif

        // Pending flags are one deep; an unaccepted start while already pending is dropped
        if (accept_wr)     wr_pend_d = 1'b0;
        else if (wr_start) wr_pend_d = 1'b1;
        if (accept_rd)     rd_pend_d = 1'b0;
        else if (rd_start) rd_pend_d = 1'b1;

        if (accept_wr | accept_rd) begin
            a_lat_d  = A;
            d_lat_d  = DIn;
            last_a_d = A;
            op_wr_d  = accept_wr;
            cnt_d    = CNT_W'(WAIT_STATES);
            done_d   = 1'b0;
            perr_d   = 1'b0;
        end

        if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_q == ST_ACCESS) begin
            done_d = 1'b1;
            if (!op_wr_q) begin
                dout_d = mem_word[DATA_W-1:0];
`ifdef DPRAM_PARITY_EN
                perr_d = ^mem_word;
`endif
            end
        end

        busy_d = (state_d != ST_IDLE) | wr_pend_d | rd_pend_d;
    end

    assign DOut = dout_q;
    assign Done = done_q;
    assign Busy = busy_q;
`ifdef DPRAM_PARITY_EN
    assign ParityErr = perr_q;
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Directed self-checking bench for dpram_access_ctrl; inputs driven and outputs sampled on negedge.
module tb_dpram_access_ctrl;
    localparam int unsigned WS  = 2;
    localparam int          LAT = WS + 2;

    logic        clk = 1'b0;
    logic        ar;
    logic [9:0]  A;
    logic [15:0] DIn;
    logic        RD, WR;
    logic [15:0] DOut;
    logic        Done, Busy, ParityErr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    logic done_prev;

    dpram_access_ctrl #(.ADDR_W(10), .DATA_W(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .ar(ar), .A(A), .DIn(DIn), .RD(RD), .WR(WR),
        .DOut(DOut), .Done(Done), .Busy(Busy), .ParityErr(ParityErr)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic wr_op(input logic [9:0] a, input logic [15:0] d);
        A = a; DIn = d; WR = 1'b1;
        cyc(1);
        WR = 1'b0;
        cyc(LAT + 1);
    endtask

    task automatic rd_chk(input string tag, input logic [9:0] a, input logic [15:0] exp);
        A = a; RD = 1'b1;
        cyc(1);
        RD = 1'b0;
        cyc(LAT);
        chk16(tag, DOut, exp);
        cyc(1);
    endtask

    initial begin
        ar = 1'b1; A = '0; DIn = '0; RD = 1'b0; WR = 1'b0;
        cyc(2);
        chk16("rst_dout", DOut, 16'h0000);
        chk1("rst_done", Done, 1'b0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_perr", ParityErr, 1'b0);
        ar = 1'b0;
        cyc(1);

        // Basic write: 1-cycle WR pulse, Done exactly LAT edges after the start sample
        A = 10'h005; DIn = 16'hBEEF; WR = 1'b1;
        cyc(1);
        WR = 1'b0;
        chk1("wr_busy", Busy, 1'b1);
        cyc(LAT - 1);
        chk1("wr_done_early", Done, 1'b0);
        cyc(1);
        chk1("wr_done", Done, 1'b1);
        chk1("wr_busy_end", Busy, 1'b0);

        // Basic read with RD held 8 cycles
        RD = 1'b1;
        cyc(LAT);
        chk1("rd_done_early", Done, 1'b0);
        cyc(1);
        chk16("rd_dout", DOut, 16'hBEEF);
        chk1("rd_done", Done, 1'b1);
        cyc(3);
        RD = 1'b0;
        cyc(2);

        // Simultaneous strobes: write first, read from pending
        wr_op(10'h010, 16'hAAAA);
        A = 10'h010; DIn = 16'h1234; RD = 1'b1; WR = 1'b1;
        cyc(LAT + 1);
        chk1("sim_wr_done", Done, 1'b1);
        chk1("sim_busy_pend", Busy, 1'b1);
        chk16("sim_dout_hold", DOut, 16'hBEEF);
        cyc(2);
        chk1("sim_busy_mid", Busy, 1'b1);
        cyc(LAT - 1);
        chk16("sim_dout", DOut, 16'h1234);
        chk1("sim_rd_done", Done, 1'b1);
        chk1("sim_busy_end", Busy, 1'b0);
        RD = 1'b0; WR = 1'b0;
        cyc(2);

        // Reset during WAIT aborts the write
        wr_op(10'h020, 16'h0F0F);
        A = 10'h020; DIn = 16'h5555; WR = 1'b1;
        cyc(1);
        ar = 1'b1; WR = 1'b0;
        cyc(1);
        chk16("arst_dout", DOut, 16'h0000);
        chk1("arst_done", Done, 1'b0);
        chk1("arst_busy", Busy, 1'b0);
        ar = 1'b0;
        cyc(1);
        rd_chk("arst_readback", 10'h020, 16'h0F0F);

        // Held-WR sweep: one write per address change
        done_prev = Done;
        WR = 1'b1;
        for (int a = 1; a < 1024; a++) begin
            A = 10'(a); DIn = 16'(a * 15);
            repeat (8) begin
                @(negedge clk);
                if (Done && !done_prev) n_done++;
                done_prev = Done;
            end
        end
        WR = 1'b0;
        cyc(2);
        chk16("sweep_wr_count", 16'(n_done), 16'd1023);

        // Read-back sweep with RD held
        RD = 1'b1;
        for (int a = 1; a < 1024; a++) begin
            A = 10'(a);
            cyc(8);
            chk16("sweep_rd", DOut, 16'(a * 15));
        end
        chk16("sweep_top", DOut, 16'h3BF1);
        chk1("sweep_perr", ParityErr, 1'b0);

        // Back-to-back reads via address change, RD still held
        A = 10'h001;
        cyc(LAT + 1);
        chk16("b2b_rd1", DOut, 16'h000F);
        cyc(7 - LAT);
        A = 10'h002;
        cyc(LAT);
        chk16("b2b_rd2_early", DOut, 16'h000F);
        cyc(1);
        chk16("b2b_rd2", DOut, 16'h001E);
        cyc(8);
        chk1("held_rd_no_retrigger", Done, 1'b1);
        RD = 1'b0;
        cyc(2);

`ifdef DPRAM_PARITY_EN
        wr_op(10'h005, 16'h00F1);
        dut.mem[5][16] = ~dut.mem[5][16];
        rd_chk("perr_data", 10'h005, 16'h00F1);
        chk1("perr_set", ParityErr, 1'b1);
        A = 10'h006; DIn = 16'h0001; WR = 1'b1;
        cyc(1);
        WR = 1'b0;
        chk1("perr_clear", ParityErr, 1'b0);
        cyc(LAT + 1);
`else
        chk1("perr_tied", ParityErr, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
